mul_result_unpack: RTL and testbench

- Downstream stage of the radix-8 Booth multiplier.
- Accepts each 67-bit sign-extended product on the cycle the multiplier signals completion and buffers it in a small FIFO.
- Range-checks each product.
- Serialises each product onto the 32-bit result bus as two beats (low word, high word) under a valid/ready handshake, so the multiplier never needs to stall.

---
 rtl/mul_result_unpack.sv | 130 +++++++++++++
 tb/tb_mul_result_unpack.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_result_unpack.sv
// mul_result_unpack: buffers 67-bit Booth multiplier products in a small FIFO,
// range-checks each one, and serialises it as two 32-bit beats on a
// valid/ready result bus.
module mul_result_unpack #(
  parameter int DEPTH    = 2,
  parameter bit LO_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prod_valid,
  input  logic [66:0] product,
  output logic        prod_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_ovf32,
  output logic        out_ext_err,
  output logic        overrun
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  // Entry layout: {lo[31:0], hi[31:0], ovf32, ext_err}
  logic [65:0]   mem_q [DEPTH];
  logic [65:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  phase_t        ph_q, ph_d;
  logic          overrun_q, overrun_d;

  logic        push;
  logic        pop;
  logic        fire;
  logic        ovf_in;
  logic        ext_in;
  logic [65:0] head;
  logic        sel_lo;

  // Handshake decode, push-time flag computation, and head-entry output mux
  always_comb begin
    ovf_in      = ~(&product[66:31] | ~|product[66:31]);
    ext_in      = ~(&product[66:63] | ~|product[66:63]);
    prod_ready  = (count_q < DEPTH_C);
    out_valid   = (count_q != '0);
    push        = prod_valid && prod_ready;
    fire        = out_valid && out_ready;
    pop         = fire && (ph_q == PH_SECOND);
    head        = mem_q[rd_ptr_q];
    sel_lo      = LO_FIRST ? (ph_q == PH_FIRST) : (ph_q == PH_SECOND);
    out_data    = '0;
    out_last    = 1'b0;
    out_ovf32   = 1'b0;
    out_ext_err = 1'b0;
    // Outputs are masked when empty so stale, never-reset storage can't leak
    if (out_valid) begin
      out_data    = sel_lo ? head[65:34] : head[33:2];
      out_last    = (ph_q == PH_SECOND);
      out_ovf32   = head[1];
      out_ext_err = head[0];
    end
    overrun = overrun_q;
  end

  // Next-state for storage, pointers, occupancy, beat phase and overrun flag
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ph_d      = ph_q;
    overrun_d = overrun_q;

    if (push) begin
      mem_d[wr_ptr_q] = {product[31:0], product[63:32], ovf_in, ext_in};
      wr_ptr_d        = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (prod_valid && !prod_ready) begin
      overrun_d = 1'b1;
    end

    if (fire) begin
      if (ph_q == PH_FIRST) begin
        ph_d = PH_SECOND;
      end else begin
        ph_d     = PH_FIRST;
        rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ph_q      <= PH_FIRST;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ph_q      <= ph_d;
      overrun_q <= overrun_d;
    end
  end

  // Product storage; contents are only observed through occupied entries
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mul_result_unpack.sv
// Directed self-checking bench for mul_result_unpack. Two instances share the
// stimulus: one sends the low word first, the other the high word first.
module tb_mul_result_unpack;

  logic        clk;
  logic        rst;
  logic        prod_valid;
  logic [66:0] product;
  logic        out_ready;

  logic        prod_ready,  prod_ready_h;
  logic [31:0] out_data,    out_data_h;
  logic        out_valid,   out_valid_h;
  logic        out_last,    out_last_h;
  logic        out_ovf32,   out_ovf32_h;
  logic        out_ext_err, out_ext_err_h;
  logic        overrun,     overrun_h;

  int unsigned n_checks;
  int unsigned n_fail;

  mul_result_unpack #(.DEPTH(2), .LO_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .product(product),
    .prod_ready(prod_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_ovf32(out_ovf32),
    .out_ext_err(out_ext_err), .overrun(overrun)
  );

  mul_result_unpack #(.DEPTH(2), .LO_FIRST(1'b0)) dut_h (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .product(product),
    .prod_ready(prod_ready_h), .out_data(out_data_h), .out_valid(out_valid_h),
    .out_ready(out_ready), .out_last(out_last_h), .out_ovf32(out_ovf32_h),
    .out_ext_err(out_ext_err_h), .overrun(overrun_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Push one product with out_ready high and check both beats on both instances
  task automatic run_prod(input string tag, input logic [66:0] p,
                          input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] h0, input logic [31:0] h1,
                          input logic ovf, input logic ext);
    @(negedge clk);
    product    = p;
    prod_valid = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    check({tag, " b0 valid"}, 64'(out_valid), 64'd1);
    check({tag, " b0 data"},  64'(out_data),  64'(b0));
    check({tag, " b0 last"},  64'(out_last),  64'd0);
    check({tag, " b0 ovf"},   64'(out_ovf32), 64'(ovf));
    check({tag, " b0 ext"},   64'(out_ext_err), 64'(ext));
    check({tag, " b0 data hf"}, 64'(out_data_h), 64'(h0));
    @(negedge clk);
    check({tag, " b1 data"},  64'(out_data),  64'(b1));
    check({tag, " b1 last"},  64'(out_last),  64'd1);
    check({tag, " b1 ovf"},   64'(out_ovf32), 64'(ovf));
    check({tag, " b1 ext"},   64'(out_ext_err), 64'(ext));
    check({tag, " b1 data hf"}, 64'(out_data_h), 64'(h1));
    check({tag, " b1 last hf"}, 64'(out_last_h), 64'd1);
    @(negedge clk);
    check({tag, " done valid"}, 64'(out_valid), 64'd0);
    check({tag, " done valid hf"}, 64'(out_valid_h), 64'd0);
  endtask

  task automatic pulse(input logic [66:0] p);
    @(negedge clk);
    product    = p;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    prod_valid = 1'b0;
    product    = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst valid",   64'(out_valid),   64'd0);
    check("rst last",    64'(out_last),    64'd0);
    check("rst data",    64'(out_data),    64'd0);
    check("rst ovf",     64'(out_ovf32),   64'd0);
    check("rst ext",     64'(out_ext_err), 64'd0);
    check("rst ready",   64'(prod_ready),  64'd1);
    check("rst overrun", 64'(overrun),     64'd0);

    run_prod("2x3", 67'd6, 32'h0000_0006, 32'h0, 32'h0, 32'h0000_0006, 1'b0, 1'b0);
    run_prod("m1x1", '1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_prod("2p32", 67'h1_0000_0000, 32'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b0);
    run_prod("malf", {3'b011, 64'h8000_0000_0000_0000}, 32'h0, 32'h8000_0000,
             32'h8000_0000, 32'h0, 1'b1, 1'b1);

    // Backpressure: fill, overflow, then drain
    @(negedge clk);
    out_ready = 1'b0;
    pulse(67'd1);
    check("bp ready after 1", 64'(prod_ready), 64'd1);
    pulse(67'd2);
    check("bp ready after 2", 64'(prod_ready), 64'd0);
    pulse(67'd3);
    check("bp overrun", 64'(overrun), 64'd1);
    check("bp head data", 64'(out_data), 64'd1);
    @(negedge clk);
    check("bp hold data", 64'(out_data), 64'd1);
    check("bp hold last", 64'(out_last), 64'd0);
    check("bp hold valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    check("bp beat0 data", 64'(out_data), 64'd1);
    @(negedge clk);
    check("bp beat1 data", 64'(out_data), 64'd0);
    check("bp beat1 last", 64'(out_last), 64'd1);
    @(negedge clk);
    check("bp beat2 data", 64'(out_data), 64'd2);
    check("bp beat2 last", 64'(out_last), 64'd0);
    @(negedge clk);
    check("bp beat3 data", 64'(out_data), 64'd0);
    check("bp beat3 last", 64'(out_last), 64'd1);
    @(negedge clk);
    check("bp drained", 64'(out_valid), 64'd0);
    check("bp overrun sticky", 64'(overrun), 64'd1);
    check("bp ready again", 64'(prod_ready), 64'd1);

    // Reset in the middle of a transfer
    out_ready = 1'b0;
    pulse(67'd7);
    pulse(67'd8);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("mid last", 64'(out_last), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst valid",   64'(out_valid),  64'd0);
    check("mid rst ready",   64'(prod_ready), 64'd1);
    check("mid rst overrun", 64'(overrun),    64'd0);
    pulse(67'd5);
    check("post rst data", 64'(out_data), 64'd5);
    check("post rst last", 64'(out_last), 64'd0);
    check("post rst valid", 64'(out_valid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
